// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle controller (master) and the datapath (slave).
// Carries the decoded instruction fields in, the per-cycle control word out, plus debug state.
interface mc_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWrite;
  logic       IRWrite;
  logic       IorD;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] WDSel;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       EXTOp;
  logic [3:0] ALUOp;
  logic [1:0] NPCOp;
  logic [3:0] state;
  logic       illegal;

  modport master (
    input  Op, Funct, Zero,
    output PCWrite, IRWrite, IorD, MemWrite, RegWrite, RegDst, WDSel,
           ALUSrcA, ALUSrcB, EXTOp, ALUOp, NPCOp, state, illegal
  );

  modport slave (
    output Op, Funct, Zero,
    input  PCWrite, IRWrite, IorD, MemWrite, RegWrite, RegDst, WDSel,
           ALUSrcA, ALUSrcB, EXTOp, ALUOp, NPCOp, state, illegal
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM (fetch/decode/execute/memory/writeback sequencing).
// Define MCCTRL_ILLEGAL_TRAP_EN to trap unrecognised instructions in a HALT state.
module mc_ctrl (
    input logic      clk,
    input logic      rstn,
    mc_ctrl_if.master bus
);
    localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3,
                           ALU_OR  = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
                           ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_LUI = 4'd10;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C,
                           OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SLLV = 6'h04, FN_SRLV = 6'h06,
                           FN_JR = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24,
                           FN_OR = 6'h25, FN_NOR = 6'h27, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0, S_DCODE = 4'd1, S_MADR  = 4'd2, S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4, S_MEMWR = 4'd5, S_EXEC  = 4'd6, S_ALUWB = 4'd7,
        S_BRANCH = 4'd8, S_JUMP  = 4'd9
`ifdef MCCTRL_ILLEGAL_TRAP_EN
        , S_HALT = 4'd10
`endif
    } state_t;

    state_t     state_q, state_d;
    logic       pcw, irw, iord, memw, regw, ext, bad;
    logic [1:0] regdst, wdsel, srca, srcb, npc;
    logic [3:0] aluop;

    // R-type funct codes that execute through EXEC/ALUWB (jr is routed to JUMP instead).
    function automatic logic [3:0] r_aluop(input logic [5:0] fn);
        case (fn)
            FN_ADDU:         r_aluop = ALU_ADD;
            FN_SUBU:         r_aluop = ALU_SUB;
            FN_AND:          r_aluop = ALU_AND;
            FN_OR:           r_aluop = ALU_OR;
            FN_NOR:          r_aluop = ALU_NOR;
            FN_SLT:          r_aluop = ALU_SLT;
            FN_SLTU:         r_aluop = ALU_SLTU;
            FN_SLL, FN_SLLV: r_aluop = ALU_SLL;
            FN_SRL, FN_SRLV: r_aluop = ALU_SRL;
            default:         r_aluop = ALU_NOP;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        pcw = 1'b0;  irw = 1'b0;  iord = 1'b0;  memw = 1'b0;  regw = 1'b0;
        ext = 1'b0;  bad = 1'b0;
        regdst = 2'b00;  wdsel = 2'b00;  srca = 2'b00;  srcb = 2'b00;  npc = 2'b00;
        aluop = ALU_NOP;
        case (state_q)
            S_FETCH: begin
                irw = 1'b1;  pcw = 1'b1;  srcb = 2'b01;  aluop = ALU_ADD;
                state_d = S_DCODE;
            end
            S_DCODE: begin
                // Precompute the branch target into ALUOut while decoding.
                srcb = 2'b11;  ext = 1'b1;  aluop = ALU_ADD;
                case (bus.Op)
                    OP_LW, OP_SW:   state_d = S_MADR;
                    OP_R: begin
                        if (bus.Funct == FN_JR)                 state_d = S_JUMP;
                        else if (r_aluop(bus.Funct) != ALU_NOP) state_d = S_EXEC;
                        else                                    bad = 1'b1;
                    end
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_EXEC;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J, OP_JAL:   state_d = S_JUMP;
                    default:        bad = 1'b1;
                endcase
`ifdef MCCTRL_ILLEGAL_TRAP_EN
                if (bad) state_d = S_HALT;
`else
                if (bad) state_d = S_FETCH;
`endif
            end
            S_MADR: begin
                srca = 2'b01;  srcb = 2'b10;  ext = 1'b1;  aluop = ALU_ADD;
                state_d = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                wdsel = 2'b01;  regw = 1'b1;
            end
            S_MEMWR: begin
                iord = 1'b1;  memw = 1'b1;
            end
            S_EXEC: begin
                state_d = S_ALUWB;
                if (bus.Op == OP_R) begin
                    srcb  = 2'b00;
                    srca  = (bus.Funct == FN_SLL || bus.Funct == FN_SRL) ? 2'b10 : 2'b01;
                    aluop = r_aluop(bus.Funct);
                end else begin
                    srca = 2'b01;  srcb = 2'b10;
                    case (bus.Op)
                        OP_ADDI: begin ext = 1'b1; aluop = ALU_ADD; end
                        OP_SLTI: begin ext = 1'b1; aluop = ALU_SLT; end
                        OP_ANDI: aluop = ALU_AND;
                        OP_ORI:  aluop = ALU_OR;
                        OP_LUI:  aluop = ALU_LUI;
                        default: aluop = ALU_NOP;
                    endcase
                end
            end
            S_ALUWB: begin
                regdst = (bus.Op == OP_R) ? 2'b01 : 2'b00;
                regw   = 1'b1;
            end
            S_BRANCH: begin
                srca = 2'b01;  aluop = ALU_SUB;  npc = 2'b01;
                pcw  = ((bus.Op == OP_BEQ) & bus.Zero) | ((bus.Op == OP_BNE) & ~bus.Zero);
            end
            S_JUMP: begin
                pcw = 1'b1;
                npc = (bus.Op == OP_R) ? 2'b11 : 2'b10;
                // PC already holds PC+4 here, so jal links the return address directly.
                if (bus.Op == OP_JAL) begin
                    regdst = 2'b10;  wdsel = 2'b10;  regw = 1'b1;
                end
            end
`ifdef MCCTRL_ILLEGAL_TRAP_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Write enables are masked by rstn so nothing commits once reset is asserted.
    assign bus.PCWrite  = pcw  & rstn;
    assign bus.IRWrite  = irw  & rstn;
    assign bus.MemWrite = memw & rstn;
    assign bus.RegWrite = regw & rstn;
    assign bus.IorD     = iord;
    assign bus.RegDst   = regdst;
    assign bus.WDSel    = wdsel;
    assign bus.ALUSrcA  = srca;
    assign bus.ALUSrcB  = srcb;
    assign bus.EXTOp    = ext;
    assign bus.ALUOp    = aluop;
    assign bus.NPCOp    = npc;
    assign bus.state    = state_q;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    assign bus.illegal  = (state_q == S_HALT);
`else
    assign bus.illegal  = 1'b0;
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-cycle expected control words are queued when an instruction
// is issued and compared against the DUT each cycle.
module tb_mc_ctrl;
  localparam logic [3:0] A_NOP = 4'd0, A_ADD = 4'd1, A_SUB = 4'd2, A_AND = 4'd3, A_OR = 4'd4,
                         A_NOR = 4'd5, A_SLT = 4'd6, A_SLTU = 4'd7, A_SLL = 4'd8, A_SRL = 4'd9,
                         A_LUI = 4'd10;
  localparam logic [3:0] ST_FETCH = 4'd0, ST_DCODE = 4'd1, ST_MADR = 4'd2, ST_MEMRD = 4'd3,
                         ST_MEMWB = 4'd4, ST_MEMWR = 4'd5, ST_EXEC = 4'd6, ST_ALUWB = 4'd7,
                         ST_BRANCH = 4'd8, ST_JUMP = 4'd9, ST_HALT = 4'd10;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, iord, memw, regw;
    logic [1:0] regdst, wdsel, srca, srcb;
    logic       ext;
    logic [3:0] aluop;
    logic [1:0] npc;
    logic       ill;
  } vec_t;

  logic clk;
  logic rstn;
  logic [24:0] exp_q[$];
  int total;
  int bad;

  mc_ctrl_if bus();
  mc_ctrl dut (.clk(clk), .rstn(rstn), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int NTAB = 26;
  logic [5:0] op_tab [NTAB] = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D,
                                6'h0F, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F, 6'h00, 6'h01};
  logic [5:0] fn_tab [NTAB] = '{6'h00, 6'h00, 6'h21, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B,
                                6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h3F, 6'h00};
  string nm_tab [NTAB] = '{"lw", "sw", "addu", "subu", "and", "or", "nor", "slt", "sltu",
                           "sll", "srl", "sllv", "srlv", "jr", "addi", "slti", "andi", "ori",
                           "lui", "beq", "bne", "j", "jal", "badop", "badfn", "badop1"};

  task automatic check_eq(input string tag, input logic [24:0] got, input logic [24:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic vec_t observed();
    vec_t v;
    v.st = bus.state;      v.pcw = bus.PCWrite;   v.irw = bus.IRWrite;  v.iord = bus.IorD;
    v.memw = bus.MemWrite; v.regw = bus.RegWrite; v.regdst = bus.RegDst; v.wdsel = bus.WDSel;
    v.srca = bus.ALUSrcA;  v.srcb = bus.ALUSrcB;  v.ext = bus.EXTOp;    v.aluop = bus.ALUOp;
    v.npc = bus.NPCOp;     v.ill = bus.illegal;
    return v;
  endfunction

  function automatic vec_t mk(input logic [3:0] st);
    vec_t v;
    v = '0;
    v.st = st;
    return v;
  endfunction

  function automatic vec_t v_fetch();
    vec_t v;
    v = mk(ST_FETCH); v.pcw = 1; v.irw = 1; v.srcb = 2'b01; v.aluop = A_ADD;
    return v;
  endfunction

  function automatic vec_t v_dcode();
    vec_t v;
    v = mk(ST_DCODE); v.srcb = 2'b11; v.ext = 1; v.aluop = A_ADD;
    return v;
  endfunction

  function automatic vec_t v_exec(input logic [1:0] sa, input logic [1:0] sb, input logic e,
                                  input logic [3:0] op);
    vec_t v;
    v = mk(ST_EXEC); v.srca = sa; v.srcb = sb; v.ext = e; v.aluop = op;
    return v;
  endfunction

  function automatic vec_t v_wb(input logic [3:0] st, input logic [1:0] dst, input logic [1:0] wd);
    vec_t v;
    v = mk(st); v.regw = 1; v.regdst = dst; v.wdsel = wd;
    return v;
  endfunction

  // Queue the whole expected cycle sequence of one instruction; returns 1 if it should trap.
  function automatic bit push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    vec_t v;
    bit   ill;
    ill = 0;
    exp_q.push_back(v_fetch());
    exp_q.push_back(v_dcode());
    case (op)
      6'h23: begin
        v = mk(ST_MADR); v.srca = 2'b01; v.srcb = 2'b10; v.ext = 1; v.aluop = A_ADD;
        exp_q.push_back(v);
        v = mk(ST_MEMRD); v.iord = 1; exp_q.push_back(v);
        exp_q.push_back(v_wb(ST_MEMWB, 2'b00, 2'b01));
      end
      6'h2B: begin
        v = mk(ST_MADR); v.srca = 2'b01; v.srcb = 2'b10; v.ext = 1; v.aluop = A_ADD;
        exp_q.push_back(v);
        v = mk(ST_MEMWR); v.iord = 1; v.memw = 1; exp_q.push_back(v);
      end
      6'h00: begin
        case (fn)
          6'h21: exp_q.push_back(v_exec(2'b01, 2'b00, 0, A_ADD));
          6'h23: exp_q.push_back(v_exec(2'b01, 2'b00, 0, A_SUB));
          6'h24: exp_q.push_back(v_exec(2'b01, 2'b00, 0, A_AND));
          6'h25: exp_q.push_back(v_exec(2'b01, 2'b00, 0, A_OR));
          6'h27: exp_q.push_back(v_exec(2'b01, 2'b00, 0, A_NOR));
          6'h2A: exp_q.push_back(v_exec(2'b01, 2'b00, 0, A_SLT));
          6'h2B: exp_q.push_back(v_exec(2'b01, 2'b00, 0, A_SLTU));
          6'h00: exp_q.push_back(v_exec(2'b10, 2'b00, 0, A_SLL));
          6'h02: exp_q.push_back(v_exec(2'b10, 2'b00, 0, A_SRL));
          6'h04: exp_q.push_back(v_exec(2'b01, 2'b00, 0, A_SLL));
          6'h06: exp_q.push_back(v_exec(2'b01, 2'b00, 0, A_SRL));
          6'h08: begin v = mk(ST_JUMP); v.pcw = 1; v.npc = 2'b11; exp_q.push_back(v); end
          default: ill = 1;
        endcase
        if (!ill && fn != 6'h08) exp_q.push_back(v_wb(ST_ALUWB, 2'b01, 2'b00));
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: begin
        case (op)
          6'h08:   exp_q.push_back(v_exec(2'b01, 2'b10, 1, A_ADD));
          6'h0A:   exp_q.push_back(v_exec(2'b01, 2'b10, 1, A_SLT));
          6'h0C:   exp_q.push_back(v_exec(2'b01, 2'b10, 0, A_AND));
          6'h0D:   exp_q.push_back(v_exec(2'b01, 2'b10, 0, A_OR));
          default: exp_q.push_back(v_exec(2'b01, 2'b10, 0, A_LUI));
        endcase
        exp_q.push_back(v_wb(ST_ALUWB, 2'b00, 2'b00));
      end
      6'h04, 6'h05: begin
        v = mk(ST_BRANCH); v.srca = 2'b01; v.aluop = A_SUB; v.npc = 2'b01;
        v.pcw = (op == 6'h04) ? z : ~z;
        exp_q.push_back(v);
      end
      6'h02, 6'h03: begin
        v = mk(ST_JUMP); v.pcw = 1; v.npc = 2'b10;
        if (op == 6'h03) begin v.regdst = 2'b10; v.wdsel = 2'b10; v.regw = 1; end
        exp_q.push_back(v);
      end
      default: ill = 1;
    endcase
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    if (ill) for (int i = 0; i < 20; i++) begin
      v = mk(ST_HALT); v.ill = 1; exp_q.push_back(v);
    end
    return ill;
`else
    return 0;
`endif
  endfunction

  // Reset view: FETCH state with every write enable held off.
  function automatic vec_t v_reset();
    vec_t v;
    v = v_fetch(); v.pcw = 0; v.irw = 0;
    return v;
  endfunction

  task automatic compare(input string tag);
    vec_t e;
    e = exp_q.pop_front();
    check_eq(tag, observed(), e);
  endtask

  task automatic do_reset(input string tag);
    rstn = 1'b0;
    exp_q.push_back(v_reset());
    exp_q.push_back(v_reset());
    #1 compare({tag, "_rst0"});
    bus.Op = 6'($urandom_range(0, 63));
    @(posedge clk); #2 compare({tag, "_rst1"});
    @(posedge clk); #1 rstn = 1'b1;
  endtask

  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z);
    int n0, n;
    bit halt;
    bit br;
    n0 = exp_q.size();
    halt = push_instr(op, fn, z);
    n = exp_q.size() - n0;
    br = (op == 6'h04 || op == 6'h05);
    for (int c = 0; c < n; c++) begin
      bus.Op = op;
      bus.Funct = fn;
      bus.Zero = (br && c == 2) ? z : 1'($urandom_range(0, 1));
      #2 compare($sformatf("%s_c%0d", name, c));
      @(posedge clk); #1;
    end
    if (halt) do_reset(name);
  endtask

  task automatic run_sw_reset();
    void'(push_instr(6'h2B, 6'h00, 1'b0));
    for (int c = 0; c < 4; c++) begin
      bus.Op = 6'h2B; bus.Funct = 6'h00; bus.Zero = 1'($urandom_range(0, 1));
      #2 compare($sformatf("swrst_c%0d", c));
      if (c < 3) begin @(posedge clk); #1; end
    end
    #1 rstn = 1'b0;
    exp_q.push_back(v_reset());
    exp_q.push_back(v_reset());
    #1 compare("swrst_drop");
    @(posedge clk); #2 compare("swrst_hold");
    @(posedge clk); #1 rstn = 1'b1;
  endtask

  initial begin
    int k;
    total = 0;
    bad = 0;
    rstn = 1'b1;
    bus.Op = 6'h00; bus.Funct = 6'h00; bus.Zero = 1'b0;
    #1 do_reset("init");
    run_instr("lw", 6'h23, 6'h00, 1'b0);
    run_instr("beq_z1", 6'h04, 6'h00, 1'b1);
    run_instr("beq_z0", 6'h04, 6'h00, 1'b0);
    run_instr("bne_z1", 6'h05, 6'h00, 1'b1);
    run_instr("bne_z0", 6'h05, 6'h00, 1'b0);
    run_instr("sll", 6'h00, 6'h00, 1'b0);
    run_instr("jal", 6'h03, 6'h00, 1'b0);
    run_instr("bad3f", 6'h3F, 6'h00, 1'b0);
    for (int i = 0; i < NTAB; i++)
      run_instr(nm_tab[i], op_tab[i], fn_tab[i], 1'($urandom_range(0, 1)));
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, NTAB - 1);
      run_instr({"rnd_", nm_tab[k]}, op_tab[k], fn_tab[k], 1'($urandom_range(0, 1)));
    end
    run_sw_reset();
    run_instr("lw_after_rst", 6'h23, 6'h00, 1'b0);
    check_eq("sb_drain", 25'(exp_q.size()), 25'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
